s1_transpose_link: RTL
======================

// Module: s1_transpose_link
// PURPOSE
//  Upstream partner of the S2 serial stage. Transmit phase: reads 18x8-bit buffer RB1 and
//  transposes it into eight 21-bit serial frames (3-bit RB2 address + 18 data bits) on sen/sd.
//  Then raises updown, hands the bus to S2, and receives 13-bit frames (5-bit RB1 address +
//  8 data bits), writing each into RB1. Ends when all 18 words are rewritten.
// PARAMETERS
//  IDLE_GAP   1   sen-high cycles inserted after each transmitted frame (>=1)
// PORTS
//  clk      in     1   system clock, all state on rising edge
//  rst      in     1   asynchronous, active-high reset
//  updown   out    1   bus direction: 0 = S1 drives sen/sd, 1 = S2 drives
//  S1_done  out    1   all 18 RB1 words received and written
//  RB1_RW   out    1   RB1 write strobe, 0 = write at next clk edge, 1 = read
//  RB1_A    out    5   RB1 address (valid 0..17)
//  RB1_D    out    8   RB1 write data
//  RB1_Q    in     8   RB1 read data, combinational from RB1_A
//  sen      inout  1   frame enable, active low; S1 drives when updown=0, else hi-Z
//  sd       inout  1   serial data; S1 drives when updown=0, else hi-Z
// BEHAVIOUR
//  Reset: updown=0, S1_done=0, RB1_RW=1, RB1_A=0, RB1_D=0, sen drive=1, sd drive=0,
//   FSM=TX_IDLE, word index j=0, receive count=0. Reset mid-operation aborts and restarts TX.
//  FSM: TX_IDLE -> TX_ADDR(3) -> TX_DATA(18) -> TX_GAP(IDLE_GAP) -> next j or TURN -> RX -> DONE.
//  TX frame j (j=0..7 ascending): sen low for exactly 21 consecutive cycles; sd driven from a
//   register, MSB first: j[2],j[1],j[0], then data bit 17..0 where data bit k = RB1[17-k][j]
//   (RB1 addresses 0..17 read in order, bit j of RB1_Q). RB1_RW stays 1 throughout TX.
//  Between frames sen high exactly IDLE_GAP cycles; never 21 +/- 1 bits (S2 counts blindly).
//  TURN: after frame 7, sen held high IDLE_GAP+1 cycles (S2 must see sen=1 with updown=0
//   to finish its last write), then updown<=1 and held 1 until reset. Tri-state enables are
//   combinational from registered updown, so no cycle has both sides driving.
//  RX: sample sd on each clk edge where sen=0; 5-bit count cleared on any edge with sen=1.
//   Bits 1..5 -> address (MSB first), bits 6..13 -> data (MSB first). On 13th bit: next cycle
//   RB1_A=addr, RB1_D=data, RB1_RW=0 for exactly one cycle, then RB1_RW=1.
//   Address >17: frame discarded, no write, not counted. Bits beyond 13 before sen rises: ignored.
//   Written-word counter (0..18) increments per accepted write; at 18, S1_done<=1 (cycle after
//   the last write strobe), FSM=DONE; further frames ignored, no more writes. S1_done sticky.
//  X/Z on sd while sen=0 in RX is captured as-is (no filtering).
// CONFIGURATION
//  S1_ROUNDTRIP_CHECK_EN defined: extra output port err (1 bit, reset 0). In RX, after the 5th
//   address bit RB1_A<=addr (read); at the 13th bit received data is compared with RB1_Q; on
//   mismatch err<=1 (sticky), write still performed. Adds at most 1 cycle before the write strobe.
//  Undefined: no err port, no compare logic; timing exactly as in BEHAVIOUR.
// TESTING
//  1. Reset, RB1[i]=8'hA5 ^ i; S2 model -> 8 frames, frame j = {j[2:0], RB1[0..17] bit j},
//     each exactly 21 sen-low cycles, IDLE_GAP=1 gaps.
//  2. After frame 7 -> sen high 2 cycles, then updown=1; sen/sd go hi-Z in that cycle.
//  3. S2 model returns transposed data for addr 0..17 -> 18 single-cycle RB1_RW=0 strobes;
//     RB1 ends equal to original; S1_done=1 one cycle after addr-17 write.
//  4. RX frame with addr 5'd20, data 8'hFF -> no write, counter unchanged; then 18 valid frames
//     -> done; a 19th frame -> no write.
//  5. rst pulse during TX frame 3 bit 10 -> all outputs at reset values immediately; TX restarts
//     at frame 0.
//  6. S1_ROUNDTRIP_CHECK_EN: corrupt bit 0 of addr-9 return -> err=1 and stays; clean run -> err=0.

Source files
------------

// File: rtl/s1_transpose_link.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | s1_transpose_link                                                         |
// | Transposes RB1 (18x8) into eight 21-bit serial frames for S2, then turns  |
// | the bus around and writes S2's 13-bit return frames back into RB1.        |
// | Option macro S1_ROUNDTRIP_CHECK_EN adds sticky port err (data compare).   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module s1_transpose_link #(
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       updown,
  output logic       S1_done,
  output logic       RB1_RW,
  output logic [4:0] RB1_A,
  output logic [7:0] RB1_D,
  input  logic [7:0] RB1_Q,
  inout  wire        sen,
  inout  wire        sd
`ifdef S1_ROUNDTRIP_CHECK_EN
  ,
  output logic       err
`endif
);

  localparam logic [2:0] TX_IDLE = 3'd0;
  localparam logic [2:0] TX_ADDR = 3'd1;
  localparam logic [2:0] TX_DATA = 3'd2;
  localparam logic [2:0] TX_GAP  = 3'd3;
  localparam logic [2:0] TURN    = 3'd4;
  localparam logic [2:0] RX      = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  localparam int GW = $clog2(IDLE_GAP + 2);

  logic [2:0]    state_q, state_d;
  logic [2:0]    j_q, j_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          sen_q, sen_d;
  logic          sd_q, sd_d;
  logic          updown_q, updown_d;
  logic          done_q, done_d;
  logic          rb1_rw_q, rb1_rw_d;
  logic [4:0]    rb1_a_q, rb1_a_d;
  logic [7:0]    rb1_d_q, rb1_d_d;
  logic [4:0]    rx_cnt_q, rx_cnt_d;
  logic [11:0]   rx_sh_q, rx_sh_d;
  logic [4:0]    wr_cnt_q, wr_cnt_d;

  logic [2:0]    j_inc;
  logic          bit_valid;
  logic          frame_end;
  logic [4:0]    frame_addr;
  logic [7:0]    frame_data;

`ifdef S1_ROUNDTRIP_CHECK_EN
  logic          err_q, err_d;
  logic [4:0]    early_addr;
`endif

  // Bus ownership follows the registered direction flag only, so the handover is glitch-free
  assign sen     = updown_q ? 1'bz : sen_q;
  assign sd      = updown_q ? 1'bz : sd_q;
  assign updown  = updown_q;
  assign S1_done = done_q;
  assign RB1_RW  = rb1_rw_q;
  assign RB1_A   = rb1_a_q;
  assign RB1_D   = rb1_d_q;

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    sen_d    = sen_q;
    sd_d     = sd_q;
    updown_d = updown_q;
    done_d   = done_q;
    rb1_rw_d = 1'b1;
    rb1_a_d  = rb1_a_q;
    rb1_d_d  = rb1_d_q;
    rx_cnt_d = rx_cnt_q;
    rx_sh_d  = rx_sh_q;
    wr_cnt_d = wr_cnt_q;
    j_inc    = j_q + 3'd1;

    case (state_q)
      TX_IDLE: begin
        state_d = TX_ADDR;
        sen_d   = 1'b0;
        sd_d    = j_q[2];
        cnt_d   = 5'd0;
      end
      TX_ADDR: begin
        if (cnt_q == 5'd2) begin
          // RB1_A is 0 here, so RB1_Q already holds word 0
          state_d = TX_DATA;
          sd_d    = RB1_Q[j_q];
          rb1_a_d = 5'd1;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
          sd_d  = (cnt_q == 5'd0) ? j_q[1] : j_q[0];
        end
      end
      TX_DATA: begin
        if (cnt_q == 5'd17) begin
          state_d = TX_GAP;
          sen_d   = 1'b1;
          sd_d    = 1'b0;
          gap_d   = GW'(1);
        end else begin
          cnt_d   = cnt_q + 5'd1;
          sd_d    = RB1_Q[j_q];
          rb1_a_d = (cnt_q == 5'd16) ? 5'd0 : cnt_q + 5'd2;
        end
      end
      TX_GAP: begin
        if (gap_q == GW'(IDLE_GAP)) begin
          if (j_q == 3'd7) begin
            state_d = TURN;
          end else begin
            j_d     = j_inc;
            state_d = TX_ADDR;
            sen_d   = 1'b0;
            sd_d    = j_inc[2];
            cnt_d   = 5'd0;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      TURN: begin
        updown_d = 1'b1;
        state_d  = RX;
      end
      default: ;
    endcase

    // Receive shifter; the count saturates at 13 so trailing bits are ignored
    bit_valid  = updown_q && !sen;
    frame_end  = bit_valid && (rx_cnt_q == 5'd12);
    frame_addr = rx_sh_q[11:7];
    frame_data = {rx_sh_q[6:0], sd};
    if (!bit_valid) begin
      rx_cnt_d = 5'd0;
    end else if (rx_cnt_q != 5'd13) begin
      rx_cnt_d = rx_cnt_q + 5'd1;
      rx_sh_d  = {rx_sh_q[10:0], sd};
    end

`ifdef S1_ROUNDTRIP_CHECK_EN
    err_d      = err_q;
    early_addr = {rx_sh_q[3:0], sd};
    if (state_q == RX && bit_valid && rx_cnt_q == 5'd4 && early_addr <= 5'd17) begin
      rb1_a_d = early_addr;
    end
    if (state_q == RX && frame_end && frame_addr <= 5'd17 && frame_data != RB1_Q) begin
      err_d = 1'b1;
    end
`endif

    if (state_q == RX && frame_end && frame_addr <= 5'd17) begin
      rb1_rw_d = 1'b0;
      rb1_a_d  = frame_addr;
      rb1_d_d  = frame_data;
      wr_cnt_d = wr_cnt_q + 5'd1;
    end
    if (state_q == RX && !rb1_rw_q && wr_cnt_q == 5'd18) begin
      done_d  = 1'b1;
      state_d = DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      j_q      <= 3'd0;
      cnt_q    <= 5'd0;
      gap_q    <= '0;
      sen_q    <= 1'b1;
      sd_q     <= 1'b0;
      updown_q <= 1'b0;
      done_q   <= 1'b0;
      rb1_rw_q <= 1'b1;
      rb1_a_q  <= 5'd0;
      rb1_d_q  <= 8'd0;
      rx_cnt_q <= 5'd0;
      rx_sh_q  <= 12'd0;
      wr_cnt_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      sen_q    <= sen_d;
      sd_q     <= sd_d;
      updown_q <= updown_d;
      done_q   <= done_d;
      rb1_rw_q <= rb1_rw_d;
      rb1_a_q  <= rb1_a_d;
      rb1_d_q  <= rb1_d_d;
      rx_cnt_q <= rx_cnt_d;
      rx_sh_q  <= rx_sh_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

`ifdef S1_ROUNDTRIP_CHECK_EN
  assign err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

endmodule
`default_nettype wire
